// File: rtl/rv_enc_pkg.sv
// Shared encoding constants for the RV32I instruction encoder/loader.
//   OP_*      : 7-bit major opcodes for the supported instruction classes
//   FMT_*     : descriptor format codes carried on in_fmt (101-111 are illegal)
//   NOP_WORD  : canonical NOP (addi x0, x0, 0) written in place of illegal descriptors
//   desc_t    : one instruction field descriptor as seen by the field packer
package rv_enc_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] FMT_R      = 3'b000;
    localparam logic [2:0] FMT_IALU   = 3'b001;
    localparam logic [2:0] FMT_LOAD   = 3'b010;
    localparam logic [2:0] FMT_STORE  = 3'b011;
    localparam logic [2:0] FMT_BRANCH = 3'b100;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [2:0]  funct3;
        logic        funct7b5;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [12:0] imm;
    } desc_t;

endpackage

// File: rtl/instr_encoder_loader_if.sv
// Descriptor stream between the boot host and the instruction encoder/loader.
//   in_valid / in_ready : valid/ready handshake, transfer when both are high
//   in_fmt, in_funct3, in_funct7b5, in_rd, in_rs1, in_rs2, in_imm : instruction fields
//   in_last             : marks the final descriptor of a load session
// Modports: master = host side (drives the descriptor), slave = loader side.
interface instr_encoder_loader_if;

    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_fmt;
    logic [2:0]  in_funct3;
    logic        in_funct7b5;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [12:0] in_imm;
    logic        in_last;

    modport master (
        output in_valid, in_fmt, in_funct3, in_funct7b5, in_rd, in_rs1, in_rs2, in_imm, in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_fmt, in_funct3, in_funct7b5, in_rd, in_rs1, in_rs2, in_imm, in_last,
        output in_ready
    );

endinterface

// File: rtl/rv_field_packer.sv
// Purely combinational descriptor -> RV32I word packer.
//   desc    in   descriptor fields (format, funct3, funct7b5, rd, rs1, rs2, 13-bit signed imm)
//   word    out  encoded instruction, NOP_WORD when the descriptor is illegal
//   illegal out  descriptor has an unknown format or an immediate that cannot be encoded
module rv_field_packer
    import rv_enc_pkg::*;
(
    input  desc_t       desc,
    output logic [31:0] word,
    output logic        illegal
);

    // I/S immediates are 12-bit signed: bit 12 must only be a copy of the sign bit.
    logic imm_fits12;
    assign imm_fits12 = (desc.imm[12] == desc.imm[11]);

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        word    = NOP_WORD;
        illegal = 1'b0;
        case (desc.fmt)
            FMT_R: begin
                word = {1'b0, desc.funct7b5, 5'b00000, desc.rs2, desc.rs1,
                        desc.funct3, desc.rd, OP_R};
            end
            FMT_IALU: begin
                if (!imm_fits12) begin
                    illegal = 1'b1;
                end else if (desc.funct3 == 3'b101) begin
                    // SRLI/SRAI: upper bits carry funct7, only the 5-bit shamt comes from imm.
                    word = {1'b0, desc.funct7b5, 5'b00000, desc.imm[4:0], desc.rs1,
                            desc.funct3, desc.rd, OP_IALU};
                end else begin
                    word = {desc.imm[11:0], desc.rs1, desc.funct3, desc.rd, OP_IALU};
                end
            end
            FMT_LOAD: begin
                if (!imm_fits12) begin
                    illegal = 1'b1;
                end else begin
                    word = {desc.imm[11:0], desc.rs1, desc.funct3, desc.rd, OP_LOAD};
                end
            end
            FMT_STORE: begin
                if (!imm_fits12) begin
                    illegal = 1'b1;
                end else begin
                    word = {desc.imm[11:5], desc.rs2, desc.rs1, desc.funct3,
                            desc.imm[4:0], OP_STORE};
                end
            end
            FMT_BRANCH: begin
                // Branch offsets are in bytes but must be halfword aligned.
                if (desc.imm[0]) begin
                    illegal = 1'b1;
                end else begin
                    word = {desc.imm[12], desc.imm[10:5], desc.rs2, desc.rs1, desc.funct3,
                            desc.imm[4:1], desc.imm[11], OP_BRANCH};
                end
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Instruction encoder/loader: accepts field descriptors, packs them into RV32I words and
// writes them sequentially into instruction memory, holding the core in reset until done.
//   clk, reset   clock and synchronous active-high reset
//   start        pulse: begin (or restart) a load session at imem address 0
//   desc         descriptor stream (slave side of instr_encoder_loader_if)
//   imem_we      imem write strobe, one cycle after a descriptor is accepted
//   imem_addr    imem word address of the write
//   imem_wdata   encoded instruction (NOP for illegal descriptors)
//   core_reset   core reset, low only once the session is complete
//   done         session complete
//   err          sticky: an illegal descriptor was seen in this session
module instr_encoder_loader
    import rv_enc_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    instr_encoder_loader_if.slave desc,
    output logic                  imem_we,
    output logic [ADDR_W-1:0]     imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  core_reset,
    output logic                  done,
    output logic                  err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // One extra bit so the pointer can represent "memory full" (== DEPTH) without wrapping.
    localparam int                PTR_W = ADDR_W + 1;
    localparam logic [PTR_W-1:0]  FULL  = PTR_W'(DEPTH);

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] slot;
    logic             accept;
    desc_t            d;
    logic [31:0]      enc_word;
    logic             enc_illegal;

    assign d = '{fmt:      desc.in_fmt,
                 funct3:   desc.in_funct3,
                 funct7b5: desc.in_funct7b5,
                 rd:       desc.in_rd,
                 rs1:      desc.in_rs1,
                 rs2:      desc.in_rs2,
                 imm:      desc.in_imm};

    rv_field_packer u_packer (
        .desc    (d),
        .word    (enc_word),
        .illegal (enc_illegal)
    );

    // wr_ptr counts committed writes; a write still held in the output register already
    // owns slot wr_ptr, so a descriptor accepted now lands one slot further on.
    assign slot = wr_ptr + PTR_W'(imem_we);

    // start takes priority over a simultaneous descriptor, which is left unconsumed.
    assign desc.in_ready = (state == S_LOAD) && (slot != FULL) && !start;
    assign accept        = desc.in_valid && desc.in_ready;

    always_comb begin
        state_next = state;
        if (start) begin
            state_next = S_LOAD;
        end else begin
            case (state)
                S_LOAD:  if (accept && desc.in_last) state_next = S_FLUSH;
                S_FLUSH: state_next = S_DONE;
                default: state_next = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state      <= S_IDLE;
            wr_ptr     <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            core_reset <= 1'b1;
        end else begin
            state   <= state_next;
            imem_we <= accept;
            if (accept) begin
                imem_addr  <= slot[ADDR_W-1:0];
                imem_wdata <= enc_word;
            end

            // A write already on the bus still completes; start only rewinds the pointer.
            if (start) begin
                wr_ptr <= '0;
            end else if (imem_we) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end

            if (start) begin
                err <= 1'b0;
            end else if (accept && enc_illegal) begin
                err <= 1'b1;
            end

            // Registered from the next state so both flags move on the same edge as state.
            done       <= (state_next == S_DONE);
            core_reset <= (state_next != S_DONE);
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader: directed steps followed by a randomized
// back-to-back burst compared against a behavioural encoding model.
module tb_instr_encoder_loader;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        imem_we;
    logic [5:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        core_reset;
    logic        done;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    bit          mon_en = 1'b0;
    int          got_addr[$];
    logic [31:0] got_data[$];
    logic [31:0] exp_data[$];

    always #5 clk = ~clk;

    instr_encoder_loader_if desc ();

    instr_encoder_loader #(.DEPTH(64), .ADDR_W(6)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .desc       (desc),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_reset (core_reset),
        .done       (done),
        .err        (err)
    );

    // Captures every imem write while the burst scoreboard is active.
    always @(negedge clk) begin
        if (mon_en && imem_we) begin
            got_addr.push_back(int'(imem_addr));
            got_data.push_back(imem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference encoder built from the instruction-format rules with plain integer arithmetic.
    function automatic logic [31:0] model_word(input int fmt, input int f3, input int b5,
                                               input int rd, input int rs1, input int rs2,
                                               input int imm, output bit bad);
        int w;
        bad = 1'b0;
        w   = 0;
        case (fmt)
            0: w = (b5 << 30) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h33;
            1, 2: begin
                if (imm < -2048 || imm > 2047) bad = 1'b1;
                else if (fmt == 1 && f3 == 5)
                    w = (b5 << 30) | ((imm & 31) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h13;
                else
                    w = ((imm & 'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7)
                        | (fmt == 1 ? 'h13 : 'h03);
            end
            3: begin
                if (imm < -2048 || imm > 2047) bad = 1'b1;
                else w = (((imm >> 5) & 'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
                         | ((imm & 31) << 7) | 'h23;
            end
            4: begin
                if (imm % 2 != 0) bad = 1'b1;
                else w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 'h3F) << 25) | (rs2 << 20)
                         | (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 'hF) << 8)
                         | (((imm >> 11) & 1) << 7) | 'h63;
            end
            default: bad = 1'b1;
        endcase
        if (bad) w = 'h13;
        return 32'(w);
    endfunction

    task automatic drive(input int fmt, input int f3, input int b5, input int rd,
                         input int rs1, input int rs2, input int imm, input bit last);
        desc.in_valid    = 1'b1;
        desc.in_fmt      = 3'(fmt);
        desc.in_funct3   = 3'(f3);
        desc.in_funct7b5 = b5[0];
        desc.in_rd       = 5'(rd);
        desc.in_rs1      = 5'(rs1);
        desc.in_rs2      = 5'(rs2);
        desc.in_imm      = 13'(imm);
        desc.in_last     = last;
    endtask

    // Called at a negedge: offers one descriptor, expects it accepted and written next cycle.
    task automatic send(input string tag, input int fmt, input int f3, input int b5,
                        input int rd, input int rs1, input int rs2, input int imm,
                        input bit last, input int exp_addr, input logic [31:0] exp_word,
                        input bit exp_err);
        drive(fmt, f3, b5, rd, rs1, rs2, imm, last);
        #1 check({tag, "_ready"}, desc.in_ready, 1);
        @(posedge clk);
        #1;
        desc.in_valid = 1'b0;
        desc.in_last  = 1'b0;
        check({tag, "_we"},   imem_we, 1);
        check({tag, "_addr"}, imem_addr, exp_addr);
        check({tag, "_data"}, imem_wdata, exp_word);
        check({tag, "_err"},  err, exp_err);
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_we"},    imem_we, 0);
        check({tag, "_addr"},  imem_addr, 0);
        check({tag, "_data"},  imem_wdata, 0);
        check({tag, "_ready"}, desc.in_ready, 0);
        check({tag, "_done"},  done, 0);
        check({tag, "_err"},   err, 0);
        check({tag, "_crst"},  core_reset, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1);
    end

    initial begin
        bit   bad;
        bit   m_err;
        logic [31:0] w;
        int   fmt, f3, b5, rd, rs1, rs2, imm;

        reset = 1'b1;
        start = 1'b0;
        desc.in_valid = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 1'b0);
        desc.in_valid = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check_reset_values("rst");
        reset = 1'b0;
        @(negedge clk);
        check("idle_ready", desc.in_ready, 0);
        check("idle_crst", core_reset, 1);

        // Session 1: legal encodings, throughput 1/cycle, completion
        pulse_start();
        check("load_crst", core_reset, 1);
        send("r_add",   0, 0, 0, 3, 1, 2, 0,     1'b0, 0, 32'h002081B3, 1'b0);
        send("r_sub",   0, 0, 1, 4, 1, 2, 0,     1'b0, 1, 32'h40208233, 1'b0);
        send("lw",      2, 2, 0, 5, 0, 0, 8,     1'b0, 2, 32'h00802283, 1'b0);
        send("sw",      3, 2, 0, 0, 0, 5, 12,    1'b0, 3, 32'h00502623, 1'b0);
        send("srai",    1, 5, 1, 6, 7, 0, 3,     1'b0, 4, 32'h4033D313, 1'b0);
        send("addi_mn", 1, 0, 0, 1, 1, 0, -2048, 1'b0, 5, 32'h80008093, 1'b0);
        send("beq",     4, 0, 0, 0, 1, 2, -8,    1'b1, 6, 32'hFE208CE3, 1'b0);
        check("flush_ready", desc.in_ready, 0);
        check("flush_done", done, 0);
        check("flush_crst", core_reset, 1);
        @(negedge clk);
        check("done_done", done, 1);
        check("done_crst", core_reset, 0);
        check("done_ready", desc.in_ready, 0);

        // Session 2: illegal descriptors become NOPs at consecutive slots, err sticky
        pulse_start();
        check("s2_err_clr", err, 0);
        check("s2_done", done, 0);
        send("beq_odd", 4, 0, 0, 0, 1, 2, 3,     1'b0, 0, 32'h00000013, 1'b1);
        send("fmt110",  6, 0, 0, 1, 1, 1, 0,     1'b0, 1, 32'h00000013, 1'b1);
        send("lw_big",  2, 2, 0, 5, 0, 0, 2048,  1'b0, 2, 32'h00000013, 1'b1);
        send("sw_low",  3, 2, 0, 0, 4, 3, -2049, 1'b0, 3, 32'h00000013, 1'b1);
        send("sw_min",  3, 2, 0, 0, 4, 3, -2048, 1'b0, 4, 32'h80322023, 1'b1);

        // start together with a valid descriptor: start wins, descriptor not consumed
        drive(0, 0, 0, 9, 9, 9, 0, 1'b0);
        start = 1'b1;
        #1 check("st_acc_ready", desc.in_ready, 0);
        @(negedge clk);
        start = 1'b0;
        desc.in_valid = 1'b0;
        check("st_acc_we", imem_we, 0);
        check("st_acc_err", err, 0);
        send("restart", 0, 0, 0, 3, 1, 2, 0, 1'b0, 0, 32'h002081B3, 1'b0);

        // Session 3: DEPTH+1 random back-to-back descriptors, scoreboarded
        pulse_start();
        mon_en = 1'b1;
        m_err  = 1'b0;
        for (int i = 0; i <= DEPTH; i++) begin
            fmt = int'($urandom_range(0, 5));
            f3  = int'($urandom_range(0, 7));
            b5  = int'($urandom_range(0, 1));
            rd  = int'($urandom_range(0, 31));
            rs1 = int'($urandom_range(0, 31));
            rs2 = int'($urandom_range(0, 31));
            imm = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 4095)) - 2048
                                              : int'($urandom_range(0, 8191)) - 4096;
            drive(fmt, f3, b5, rd, rs1, rs2, imm, 1'b0);
            #1;
            if (i < DEPTH) begin
                w = model_word(fmt, f3, b5, rd, rs1, rs2, imm, bad);
                exp_data.push_back(w);
                m_err = m_err | bad;
            end
            check($sformatf("burst_ready%0d", i), desc.in_ready, (i < DEPTH) ? 1 : 0);
            @(negedge clk);
        end
        desc.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        mon_en = 1'b0;
        check("burst_count", got_data.size(), DEPTH);
        for (int k = 0; k < DEPTH && k < got_data.size(); k++) begin
            check($sformatf("burst_addr%0d", k), got_addr[k], k);
            check($sformatf("burst_data%0d", k), got_data[k], exp_data[k]);
        end
        check("full_we", imem_we, 0);
        check("full_ready", desc.in_ready, 0);
        check("full_err", err, m_err);
        check("full_done", done, 0);

        // Reset in the middle of a session
        pulse_start();
        send("pre_rst", 7, 0, 0, 0, 0, 0, 0, 1'b0, 0, 32'h00000013, 1'b1);
        drive(0, 0, 0, 3, 1, 2, 0, 1'b0);
        @(posedge clk);
        #1 desc.in_valid = 1'b0;
        check("pre_rst_we", imem_we, 1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 check_reset_values("mid_rst");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
